// File: rtl/sd_dma.sv
// sd_dma: moves 32-bit words between the SD data FIFO and the memory bus,
// keeping at most one bus access outstanding.
module sd_dma #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LENGTH_WIDTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_direction,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [LENGTH_WIDTH-1:0]  i_length,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [LENGTH_WIDTH-1:0]  o_remaining,
  input  logic                     i_fifo_empty,
  input  logic                     i_fifo_full,
  input  logic                     i_fifo_underrun,
  input  logic                     i_fifo_overrun,
  input  logic [31:0]              i_fifo_data,
  output logic                     o_fifo_pop,
  output logic                     o_fifo_push,
  output logic [31:0]              o_fifo_data,
  output logic                     o_mem_request,
  output logic                     o_mem_write,
  output logic [ADDRESS_WIDTH-1:0] o_mem_address,
  output logic [31:0]              o_mem_wdata,
  input  logic                     i_mem_ack,
  input  logic [31:0]              i_mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_PUSH = 2'd3;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP  = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ALIGN = ~ADDRESS_WIDTH'(3);
  localparam logic [LENGTH_WIDTH-1:0]  LEN_ONE    = LENGTH_WIDTH'(1);

  logic [1:0]               state_q, state_d;
  logic                     dir_q, dir_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     stop_q, stop_d;
  logic [LENGTH_WIDTH-1:0]  remaining_q, remaining_d;
  logic                     pop_q, pop_d;
  logic                     push_q, push_d;
  logic [31:0]              fifo_data_q, fifo_data_d;
  logic                     req_q, req_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;

  // Next-state logic for the transfer sequencer
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    stop_d      = stop_q;
    remaining_d = remaining_q;
    pop_d       = 1'b0;
    push_d      = 1'b0;
    fifo_data_d = fifo_data_q;
    req_d       = req_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    if (busy_q && (i_fifo_underrun || i_fifo_overrun)) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end
    // A stop seen mid-access is remembered until the next bus-idle point
    if (busy_q && i_stop) begin
      stop_d = 1'b1;
    end else begin
      stop_d = stop_q;
    end

    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (i_start) begin
          if (i_length == '0) begin
            done_d = 1'b1;
          end else begin
            dir_d       = i_direction;
            addr_d      = i_address & ADDR_ALIGN;
            remaining_d = i_length;
            busy_d      = 1'b1;
            error_d     = 1'b0;
            state_d     = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_stop || stop_q || (remaining_q == '0)) begin
          done_d  = (remaining_q == '0) && !i_stop && !stop_q;
          busy_d  = 1'b0;
          stop_d  = 1'b0;
          state_d = S_IDLE;
        end else if (dir_q) begin
          if (!i_fifo_empty) begin
            wdata_d = i_fifo_data;
            pop_d   = 1'b1;
            req_d   = 1'b1;
            write_d = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_WAIT;
          end
        end else if (!i_fifo_full) begin
          req_d   = 1'b1;
          write_d = 1'b0;
          state_d = S_REQ;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_REQ: begin
        if (i_mem_ack) begin
          req_d       = 1'b0;
          addr_d      = addr_q + ADDR_STEP;
          remaining_d = remaining_q - LEN_ONE;
          if (dir_q) begin
            state_d = S_WAIT;
          end else begin
            fifo_data_d = i_mem_rdata;
            push_d      = 1'b1;
            state_d     = S_PUSH;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      // One settle cycle so i_fifo_full reflects the push before WAIT looks at it
      S_PUSH: begin
        state_d = S_WAIT;
      end
      default: begin
        busy_d  = 1'b0;
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      stop_q      <= 1'b0;
      remaining_q <= '0;
      pop_q       <= 1'b0;
      push_q      <= 1'b0;
      fifo_data_q <= 32'd0;
      req_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      stop_q      <= stop_d;
      remaining_q <= remaining_d;
      pop_q       <= pop_d;
      push_q      <= push_d;
      fifo_data_q <= fifo_data_d;
      req_q       <= req_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_remaining   = remaining_q;
  assign o_fifo_pop    = pop_q;
  assign o_fifo_push   = push_q;
  assign o_fifo_data   = fifo_data_q;
  assign o_mem_request = req_q;
  assign o_mem_write   = write_q;
  assign o_mem_address = addr_q;
  assign o_mem_wdata   = wdata_q;

endmodule

// File: tb/tb_sd_dma.sv
// tb_sd_dma: randomized scoreboard bench for sd_dma with a FIFO model and a
// memory responder; expectations are derived from each transfer's config.
module tb_sd_dma;

  logic        clk;
  logic        i_reset, i_start, i_stop, i_direction;
  logic [31:0] i_address;
  logic [15:0] i_length;
  logic        o_busy, o_done, o_error;
  logic [15:0] o_remaining;
  logic        i_fifo_empty, i_fifo_full, i_fifo_underrun, i_fifo_overrun;
  logic [31:0] i_fifo_data;
  logic        o_fifo_pop, o_fifo_push;
  logic [31:0] o_fifo_data;
  logic        o_mem_request, o_mem_write;
  logic [31:0] o_mem_address, o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  sd_dma #(.ADDRESS_WIDTH(32), .LENGTH_WIDTH(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_direction(i_direction), .i_address(i_address), .i_length(i_length),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_remaining(o_remaining),
    .i_fifo_empty(i_fifo_empty), .i_fifo_full(i_fifo_full),
    .i_fifo_underrun(i_fifo_underrun), .i_fifo_overrun(i_fifo_overrun),
    .i_fifo_data(i_fifo_data), .o_fifo_pop(o_fifo_pop), .o_fifo_push(o_fifo_push),
    .o_fifo_data(o_fifo_data), .o_mem_request(o_mem_request), .o_mem_write(o_mem_write),
    .o_mem_address(o_mem_address), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } acc_t;

  acc_t        exp_acc[$];
  logic [31:0] exp_push[$];
  logic [31:0] fifo_q[$];
  int          exp_done  = 0;
  int          exp_pops  = 0;
  int          pop_cnt   = 0;
  int          checks    = 0;
  int          errors    = 0;
  int          ack_lat   = 0;
  bit          rand_full = 1'b0;
  bit          full_hold = 1'b0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Environment: FIFO model and memory responder, updated on the falling edge
  initial begin
    int lat;
    bit seen;
    lat = 0;
    seen = 1'b0;
    i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
    i_fifo_full = 1'b0; i_fifo_empty = 1'b1; i_fifo_data = 32'd0;
    forever begin
      @(negedge clk);
      if (o_fifo_pop === 1'b1) begin
        pop_cnt++;
        chk("pop_nonempty", {31'd0, fifo_q.size() != 0}, 32'd1);
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      i_fifo_empty = (fifo_q.size() == 0);
      i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
      i_fifo_full  = full_hold | (rand_full & ($urandom_range(0, 2) == 0));
      if (i_mem_ack) begin
        i_mem_ack = 1'b0;
        seen = 1'b0;
      end else if (o_mem_request === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          lat = (ack_lat < 0) ? int'($urandom_range(0, 3)) : ack_lat;
        end
        if (lat == 0) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = mem_word(o_mem_address);
        end else begin
          lat--;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request, push or done
  initial begin
    bit   prev;
    acc_t cur;
    acc_t e;
    prev = 1'b0;
    cur.addr = 32'd0; cur.wr = 1'b0; cur.data = 32'd0;
    forever begin
      @(negedge clk);
      if (i_reset == 1'b0) begin
        if (o_mem_request && !prev) begin
          chk("req_expected", {31'd0, exp_acc.size() != 0}, 32'd1);
          if (exp_acc.size() != 0) begin
            e = exp_acc.pop_front();
            chk("req_addr", o_mem_address, e.addr);
            chk("req_write", {31'd0, o_mem_write}, {31'd0, e.wr});
            if (e.wr) chk("req_wdata", o_mem_wdata, e.data);
          end
          cur.addr = o_mem_address; cur.wr = o_mem_write; cur.data = o_mem_wdata;
        end else if (o_mem_request) begin
          chk("req_addr_stable", o_mem_address, cur.addr);
          chk("req_write_stable", {31'd0, o_mem_write}, {31'd0, cur.wr});
          chk("req_wdata_stable", o_mem_wdata, cur.data);
        end
        prev = o_mem_request;
        if (o_fifo_push) begin
          chk("push_expected", {31'd0, exp_push.size() != 0}, 32'd1);
          if (exp_push.size() != 0) chk("push_data", o_fifo_data, exp_push.pop_front());
        end
        if (o_done) begin
          chk("done_expected", {31'd0, exp_done > 0}, 32'd1);
          exp_done--;
        end
      end
    end
  end

  task automatic start_xfer(bit dir, logic [31:0] addr, logic [15:0] len,
                            int n_exp, bit want_done);
    acc_t a;
    @(negedge clk);
    i_start = 1'b1; i_direction = dir; i_address = addr; i_length = len;
    for (int k = 0; k < n_exp; k++) begin
      a.addr = (addr & ~32'd3) + 32'(4 * k);
      a.wr   = dir;
      a.data = dir ? fifo_q[k] : 32'd0;
      exp_acc.push_back(a);
      if (!dir) exp_push.push_back(mem_word(a.addr));
    end
    if (dir) exp_pops += n_exp;
    if (want_done) exp_done++;
    @(negedge clk);
    i_start = 1'b0;
    if (len == 16'd0 && want_done) chk("len0_done_pulse", {31'd0, o_done}, 32'd1);
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (o_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n_req;
    bit dir;
    logic [31:0] addr;
    logic [15:0] len;
    i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_direction = 1'b0;
    i_address = 32'd0; i_length = 16'd0;
    i_fifo_underrun = 1'b0; i_fifo_overrun = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_error", {31'd0, o_error}, 32'd0);
    chk("rst_remaining", {16'd0, o_remaining}, 32'd0);
    chk("rst_req", {31'd0, o_mem_request}, 32'd0);
    chk("rst_addr", o_mem_address, 32'd0);
    chk("rst_pop_push", {30'd0, o_fifo_pop, o_fifo_push}, 32'd0);
    i_reset = 1'b0;

    // Card write: three reads from 0x100 pushed in order
    ack_lat = 0;
    start_xfer(1'b0, 32'h100, 16'd3, 3, 1'b1);
    wait_idle("t1_idle");
    chk("t1_remaining", {16'd0, o_remaining}, 32'd0);

    // Card read: two preloaded words written out
    fifo_q.push_back(32'hA);
    fifo_q.push_back(32'hB);
    start_xfer(1'b1, 32'h40, 16'd2, 2, 1'b1);
    wait_idle("t2_idle");
    chk("t2_fifo_drained", 32'(fifo_q.size()), 32'd0);

    // FIFO full stalls the read; a start while busy is ignored; overrun is sticky
    full_hold = 1'b1;
    start_xfer(1'b0, 32'h302, 16'd1, 1, 1'b1);
    n_req = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_mem_request) n_req++;
    end
    start_xfer(1'b1, 32'h500, 16'd5, 0, 1'b0);
    chk("t3_cfg_kept", {16'd0, o_remaining}, 32'd1);
    i_fifo_overrun = 1'b1;
    @(negedge clk);
    i_fifo_overrun = 1'b0;
    chk("t3_error_set", {31'd0, o_error}, 32'd1);
    if (o_mem_request) n_req++;
    chk("t3_no_req_while_full", 32'(n_req), 32'd0);
    full_hold = 1'b0;
    wait_idle("t3_idle");
    chk("t3_error_sticky", {31'd0, o_error}, 32'd1);

    // Zero-length start, then an accepted start clears the error
    start_xfer(1'b0, 32'h700, 16'd0, 0, 1'b1);
    start_xfer(1'b0, 32'h600, 16'd1, 1, 1'b1);
    chk("error_cleared", {31'd0, o_error}, 32'd0);
    wait_idle("t4_idle");

    // Stop while a slow write is pending
    ack_lat = 5;
    for (int k = 0; k < 4; k++) fifo_q.push_back(32'h1000 + 32'(k));
    start_xfer(1'b1, 32'h200, 16'd4, 1, 1'b0);
    for (int i = 0; i < 50 && !o_mem_request; i++) @(negedge clk);
    chk("t5_req_seen", {31'd0, o_mem_request}, 32'd1);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    wait_idle("t5_idle");
    chk("t5_remaining", {16'd0, o_remaining}, 32'd3);
    fifo_q.delete();

    // Randomized transfers, including an address wrap
    ack_lat = -1;
    rand_full = 1'b1;
    for (int t = 0; t < 24; t++) begin
      dir  = 1'($urandom_range(0, 1));
      addr = (t == 0) ? 32'hFFFF_FFF9 : $urandom;
      len  = 16'($urandom_range(1, 6));
      if (dir) for (int k = 0; k < int'(len); k++) fifo_q.push_back($urandom);
      start_xfer(dir, addr, len, int'(len), 1'b1);
      wait_idle("rand_idle");
      chk("rand_remaining", {16'd0, o_remaining}, 32'd0);
    end
    rand_full = 1'b0;

    repeat (5) @(negedge clk);
    chk("acc_left", 32'(exp_acc.size()), 32'd0);
    chk("push_left", 32'(exp_push.size()), 32'd0);
    chk("done_left", 32'(exp_done), 32'd0);
    chk("pop_count", 32'(pop_cnt), 32'(exp_pops));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
